mem_arbiter: RTL
================

# mem_arbiter

Two-client memory arbiter between the L1 caches and the single external memory port. It accepts icache line fills and dcache line fills or stores, serialises them onto one `mem_*` port, and returns line data and a completion pulse to the requesting cache. Memory starts a transfer on a rising edge of `mem_rd` or `mem_wr`, so the arbiter guarantees a low cycle between transactions.

## Interface
- `LINE_W`, default `` `CMEM_LINE ``: cache line width in bits; a multiple of 64.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `ic_addr`  in  64  icache fill address
- `ic_rd`  in  1  icache read request (level)
- `ic_rdata`  out  LINE_W  icache fill data
- `ic_dv`  out  1  icache completion pulse
- `dc_addr`  in  64  dcache address
- `dc_wdata`  in  64  store data, little-endian byte lanes
- `dc_len`  in  2  store size: 2^len bytes
- `dc_rd`  in  1  dcache line fill request (level)
- `dc_wr`  in  1  dcache store request (level)
- `dc_rdata`  out  LINE_W  dcache fill data
- `dc_dv`  out  1  dcache completion pulse
- `mem_addr`  out  64  memory address
- `mem_wdata`  out  64  memory write data
- `mem_len`  out  2  memory write size
- `mem_rd`  out  1  memory read strobe (level, edge-sensed)
- `mem_wr`  out  1  memory write strobe (level, edge-sensed)
- `mem_rdata`  in  LINE_W  memory line data
- `mem_dv`  in  1  memory read-data-valid, single-cycle pulse

## Operation
**Client rules**
- A request is held until the client samples its `*_dv`.
- The client drops the request on that same clock edge.
- `dc_rd` and `dc_wr` must not be high together. If they are, the write wins.

**FSM states:** IDLE, RD, WR, GAP.

**IDLE**
- Pick a client:
  - If only one client requests, grant it.
  - If both request, grant the client not granted last. The last-grant register resets to icache, so the dcache wins the first tie.
- Latch `addr`, `wdata`, `len` and the grant into registers.
- A read goes to RD and a write goes to WR.

**RD**
- `mem_rd` = 1.
- `mem_addr` = latched address with the low log2(LINE_W/8) bits cleared (line-aligned).
- When `mem_dv` = 1: capture `mem_rdata` into the granted client's `rdata`, pulse its `dv`, and go to GAP.

**WR**
- `mem_wr` = 1 for exactly one cycle.
- `mem_addr`, `mem_wdata`, `mem_len` carry the latched values, unaligned.
- Pulse `dc_dv` and go to GAP.

**GAP**
- `mem_rd` = `mem_wr` = 0 for exactly one cycle, then go to IDLE.

**Other rules**
- A `mem_dv` arriving in any state other than RD is ignored.
- `*_rdata` holds its value until the next fill for that client. The other client's `rdata` is never modified.
- `mem_addr`, `mem_wdata` and `mem_len` stay stable from the first strobe cycle until the end of GAP.

## Timing
- All outputs are registered.
- **Reset values:** `mem_rd` = `mem_wr` = 0, `mem_addr`/`mem_wdata`/`mem_len` = 0, `*_dv` = 0, `*_rdata` = 0. State = IDLE, last-grant = icache.
- **Read:** request sampled in IDLE at cycle 0; `mem_rd` high from cycle 1; client `dv` one cycle after `mem_dv`. With an 8-stage memory, `mem_dv` is in cycle 9 and `dv` in cycle 10.
- **Write:** request at cycle 0; `mem_wr` in cycle 1; `dc_dv` in cycle 2; next grant possible in cycle 3.
- `*_dv` is exactly one cycle wide and coincides with GAP.
- Back-to-back transactions always have at least one cycle with both strobes low.
- **Reset mid-transaction:** at the next edge, return to IDLE with all outputs at reset values and no `dv` pulse. Any in-flight `mem_dv` is dropped.

## Structure
- Shared package `rv6_mem_pkg`:
  - `arb_state_t` enum (IDLE/RD/WR/GAP)
  - `arb_client_t` enum (IC/DC)
  - `MEM_LEN_B/H/W/D` constants (0..3)
- `LINE_W` comes from `config.vh`.
- Sub-module `mem_arb_rr`: a two-way round-robin picker with a last-grant register, and `req[1:0]`, `take`, `gnt[1:0]` ports.

## Test plan
- **icache fill:** `ic_rd`, `ic_addr` = 0x8000_0044, LINE_W = 256 -> `mem_addr` = 0x8000_0040, `ic_rdata` = memory bytes 0x40..0x5F, `ic_dv` in cycle 10.
- **Store:** `dc_wr`, addr 0x8000_0103, wdata 0xAABB, len 1 -> one `mem_wr` cycle with identical addr/wdata/len, `dc_dv` in cycle 2, memory bytes 0x103 = 0xBB and 0x104 = 0xAA.
- **Contention:** `ic_rd` and `dc_rd` both high from reset -> dcache served first, icache second, with a GAP cycle between strobes.
- **Back-to-back stores:** two dcache stores -> `mem_wr` pattern 1,0,0,1 across cycles 1..4; memory sees two rising edges.
- **Reset in RD:** `rst_n` low for one cycle mid-wait -> `mem_rd` = 0 next cycle, no `ic_dv`, and a late `mem_dv` is ignored.

Source files
------------

// File: rtl/rv6_mem_pkg.sv
// rtl/rv6_mem_pkg.sv - shared types and constants for the L1-to-memory arbiter
`ifndef CMEM_LINE
`define CMEM_LINE 256
`endif

package rv6_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } arb_client_t;

  localparam logic [1:0] MEM_LEN_B = 2'd0;
  localparam logic [1:0] MEM_LEN_H = 2'd1;
  localparam logic [1:0] MEM_LEN_W = 2'd2;
  localparam logic [1:0] MEM_LEN_D = 2'd3;

  function automatic int unsigned len_bytes(input logic [1:0] len);
    case (len)
      MEM_LEN_B: return 1;
      MEM_LEN_H: return 2;
      MEM_LEN_W: return 4;
      MEM_LEN_D: return 8;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin picker; bit 0 is the icache, bit 1 the dcache
module mem_arb_rr
  import rv6_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic [1:0] gnt_o
);

  arb_client_t last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // On a tie the client that did not win last time goes first
      2'b11:   gnt_o = (last_q == IC) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (take_i && gnt_o[1]) begin
      last_d = DC;
    end else if (take_i && gnt_o[0]) begin
      last_d = IC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= IC;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises icache fills and dcache fills/stores onto one memory port
module mem_arbiter
  import rv6_mem_pkg::*;
#(
  parameter int LINE_W = `CMEM_LINE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       ic_addr_i,
  input  logic              ic_rd_i,
  output logic [LINE_W-1:0] ic_rdata_o,
  output logic              ic_dv_o,
  input  logic [63:0]       dc_addr_i,
  input  logic [63:0]       dc_wdata_i,
  input  logic [1:0]        dc_len_i,
  input  logic              dc_rd_i,
  input  logic              dc_wr_i,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              dc_dv_o,
  output logic [63:0]       mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  output logic [1:0]        mem_len_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_dv_i
);

  localparam logic [63:0] LINE_MASK = ~(64'(LINE_W / 8) - 64'd1);

  arb_state_t        state_q, state_d;
  arb_client_t       client_q, client_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [63:0]       mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_len_q, mem_len_d;
  logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
  logic              ic_dv_q, ic_dv_d;
  logic              dc_dv_q, dc_dv_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       take;

  assign req  = {dc_rd_i | dc_wr_i, ic_rd_i};
  assign take = (state_q == IDLE) && (req != 2'b00);

  mem_arb_rr u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .take_i (take),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d     = state_q;
    client_d    = client_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_len_d   = mem_len_q;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    ic_dv_d     = 1'b0;
    dc_dv_d     = 1'b0;

    case (state_q)
      IDLE: begin
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        if (gnt[1]) begin
          client_d = DC;
          // A store beats a fill if the dcache raises both
          if (dc_wr_i) begin
            state_d     = WR;
            mem_wr_d    = 1'b1;
            mem_addr_d  = dc_addr_i;
            mem_wdata_d = dc_wdata_i;
            mem_len_d   = dc_len_i;
          end else begin
            state_d    = RD;
            mem_rd_d   = 1'b1;
            mem_addr_d = dc_addr_i & LINE_MASK;
          end
        end else if (gnt[0]) begin
          client_d   = IC;
          state_d    = RD;
          mem_rd_d   = 1'b1;
          mem_addr_d = ic_addr_i & LINE_MASK;
        end
      end

      RD: begin
        if (mem_dv_i) begin
          mem_rd_d = 1'b0;
          state_d  = GAP;
          if (client_q == DC) begin
            dc_rdata_d = mem_rdata_i;
            dc_dv_d    = 1'b1;
          end else begin
            ic_rdata_d = mem_rdata_i;
            ic_dv_d    = 1'b1;
          end
        end
      end

      WR: begin
        mem_wr_d = 1'b0;
        dc_dv_d  = 1'b1;
        state_d  = GAP;
      end

      GAP: begin
        // Both strobes low here so memory sees a fresh rising edge next time
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      client_q    <= IC;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      mem_len_q   <= MEM_LEN_B;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      ic_dv_q     <= 1'b0;
      dc_dv_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      client_q    <= client_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_len_q   <= mem_len_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      ic_dv_q     <= ic_dv_d;
      dc_dv_q     <= dc_dv_d;
    end
  end

  assign ic_rdata_o  = ic_rdata_q;
  assign ic_dv_o     = ic_dv_q;
  assign dc_rdata_o  = dc_rdata_q;
  assign dc_dv_o     = dc_dv_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_len_o   = mem_len_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;

endmodule
